// File: rtl/pc_gen.sv
// pc_gen: fetch address / fetch enable generator for the pipeline front end.
// Latency: one cycle from any redirect (flush, branch, BTB hit) to pc; outputs registered except the BTB prediction.
// Backpressure: stall[0] holds pc; flush overrides stall; a branch presented during stall is dropped.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   stall[5:0]                ctrl stall vector (bit 0 only)
//   flush_i, new_pc_i         exception/flush redirect (highest priority)
//   branch_flag_i,
//   branch_target_address_i   id branch/jump redirect
//   upd_valid_i, upd_pc_i,
//   upd_target_i, upd_taken_i resolved-branch update of the BTB
//   pc, ce                    fetch address and fetch enable
//   pred_taken_o,
//   pred_target_o             BTB prediction for the current pc
//
// Optional feature: define PC_GEN_BTB_EN to build the direct-mapped branch
// target buffer. Without it the prediction outputs are tied to zero and the
// update port is ignored.

module pc_gen #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        STEP         = 4,
  parameter int unsigned        BTB_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q;
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_tgt;

`ifdef PC_GEN_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_DEPTH-1:0] vld_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  // Lookup reads the registered arrays, so an update at this edge is only
  // seen from the next cycle on.
  assign btb_hit = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign btb_tgt = btb_hit ? tgt_q[lk_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        vld_q[up_idx] <= 1'b1;
      end else if (tag_q[up_idx] == up_tag) begin
        // Only drop the entry if it belongs to this branch; an aliasing
        // not-taken branch must not evict someone else's prediction.
        vld_q[up_idx] <= 1'b0;
      end
    end
  end

  // Tags and targets are qualified by vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= {upd_target_i[ADDR_W-1:1], 1'b0};
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{stall[5:1], new_pc_i[0], branch_target_address_i[0],
                         upd_pc_i[1:0], upd_target_i[0]};
`else
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;

  logic        unused_sigs;
  logic [31:0] unused_depth;
  assign unused_sigs  = ^{stall[5:1], new_pc_i[0], branch_target_address_i[0],
                          upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i};
  assign unused_depth = 32'(BTB_DEPTH);
`endif

  // Next-pc priority: disabled > flush > stall > branch > prediction > step.
  always_comb begin
    pc_d = pc_q;
    if (!ce_q) begin
      pc_d = RESET_VECTOR;
    end else if (flush_i) begin
      pc_d = {new_pc_i[ADDR_W-1:1], 1'b0};
    end else if (stall[0]) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d = {branch_target_address_i[ADDR_W-1:1], 1'b0};
    end else if (btb_hit) begin
      pc_d = btb_tgt;
    end else begin
      pc_d = pc_q + ADDR_W'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ce_q <= 1'b0;
      pc_q <= RESET_VECTOR;
    end else begin
      ce_q <= 1'b1;
      pc_q <= pc_d;
    end
  end

  assign pc            = pc_q;
  assign ce            = ce_q;
  assign pred_taken_o  = btb_hit;
  assign pred_target_o = btb_tgt;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table, hand-written BTB sequences and randomized
// traffic against a behavioural model of the fetch pc rules.
module tb_pc_gen;

  localparam int DEPTH = 8;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc;
  logic        ce;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .upd_valid_i             (upd_valid_i),
    .upd_pc_i                (upd_pc_i),
    .upd_target_i            (upd_target_i),
    .upd_taken_i             (upd_taken_i),
    .pc                      (pc),
    .ce                      (ce),
    .pred_taken_o            (pred_taken_o),
    .pred_target_o           (pred_target_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each BTB slot remembers the full address of the branch
  // that wrote it; a fetch address hits when it lands in the same slot and
  // lies in the same 4*DEPTH-byte aligned region.
  logic        m_ce;
  logic [31:0] m_pc;
  bit          m_vld [DEPTH];
  logic [31:0] m_owner [DEPTH];
  logic [31:0] m_tgt [DEPTH];

  function automatic int slot_of(logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit same_region(logic [31:0] a, logic [31:0] b);
    return (a / (4 * DEPTH)) == (b / (4 * DEPTH));
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    if (!BTB_ON) return 1'b0;
    return m_vld[slot_of(a)] && same_region(m_owner[slot_of(a)], a);
  endfunction

  function automatic logic [31:0] m_pred(logic [31:0] a);
    return m_hit(a) ? m_tgt[slot_of(a)] : 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    int s;
    if (!rst) begin
      m_ce = 1'b0;
      m_pc = 32'h0;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    end else begin
      if (!m_ce)                nxt = 32'h0;
      else if (flush_i)         nxt = new_pc_i & ~32'h1;
      else if (stall[0])        nxt = m_pc;
      else if (branch_flag_i)   nxt = branch_target_address_i & ~32'h1;
      else if (m_hit(m_pc))     nxt = m_pred(m_pc);
      else                      nxt = m_pc + 32'd4;
      if (upd_valid_i) begin
        s = slot_of(upd_pc_i);
        if (upd_taken_i) begin
          m_vld[s]   = 1'b1;
          m_owner[s] = upd_pc_i;
          m_tgt[s]   = upd_target_i & ~32'h1;
        end else if (m_vld[s] && same_region(m_owner[s], upd_pc_i)) begin
          m_vld[s] = 1'b0;
        end
      end
      m_ce = 1'b1;
      m_pc = nxt;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance one edge, then compare every output against the model.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ce", 32'(ce), 32'(m_ce));
    chk("pc", pc, m_pc);
    chk("pred_taken", 32'(pred_taken_o), 32'(m_hit(m_pc)));
    chk("pred_target", pred_target_o, m_pred(m_pc));
  endtask

  task automatic idle_inputs();
    rst = 1'b1; stall = '0; flush_i = 1'b0; new_pc_i = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_taken_i = 1'b0;
  endtask

  task automatic upd(logic [31:0] a, logic [31:0] t, logic tk);
    upd_valid_i = 1'b1; upd_pc_i = a; upd_target_i = t; upd_taken_i = tk;
  endtask

  task automatic br(logic [31:0] t);
    branch_flag_i = 1'b1; branch_target_address_i = t;
  endtask

  typedef struct {
    logic        rst;
    logic        stall0;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] br_tgt;
    logic [31:0] exp_pc;
    logic        exp_ce;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h4,        1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h8,        1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h101, 32'h100,      1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h104,      1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,   32'h8,        1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h101, 32'h8,        1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'hC,        1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h200,      1'b1, 32'h40,  32'h200,      1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 32'h0,   32'hFFFFFFFC, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h301,      1'b1, 32'h500, 32'h300,      1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h400,      1'b0, 32'h0,   32'h0,        1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h4,        1'b1};

    m_ce = 1'b0;
    m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0; m_owner[i] = '0; m_tgt[i] = '0;
    end
    idle_inputs();

    // Directed table: reset, branch vs stall, flush priority, wrap.
    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      rst = tbl[i].rst;
      stall[0] = tbl[i].stall0;
      flush_i = tbl[i].flush;
      new_pc_i = tbl[i].new_pc;
      branch_flag_i = tbl[i].br;
      branch_target_address_i = tbl[i].br_tgt;
      tick();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_ce", i), 32'(ce), 32'(tbl[i].exp_ce));
    end

    // BTB write, hit and redirect through the prediction.
    idle_inputs(); upd(32'h10, 32'h81, 1'b1); br(32'h10); tick();
    chk("btb_hit", 32'(pred_taken_o), 32'(BTB_ON));
    chk("btb_tgt", pred_target_o, BTB_ON ? 32'h80 : 32'h0);
    idle_inputs(); tick();
    chk("btb_follow", pc, BTB_ON ? 32'h80 : 32'h14);

    // Not-taken update with aliasing tag leaves the entry alone.
    idle_inputs(); upd(32'h30, 32'h0, 1'b0); br(32'h10); tick();
    chk("alias_keep", 32'(pred_taken_o), 32'(BTB_ON));
    idle_inputs(); tick();
    chk("alias_follow", pc, BTB_ON ? 32'h80 : 32'h14);

    // Not-taken update with matching tag invalidates; same-edge lookup old.
    idle_inputs(); upd(32'h10, 32'h0, 1'b0); br(32'h10); tick();
    chk("inval_hit", 32'(pred_taken_o), 32'h0);
    idle_inputs(); tick();
    chk("inval_follow", pc, 32'h14);

    // Populate, then reset mid-run clears all entries.
    idle_inputs(); upd(32'h10, 32'h80, 1'b1); upd_valid_i = 1'b1; tick();
    idle_inputs(); upd(32'h24, 32'h200, 1'b1); br(32'h10); tick();
    chk("repop_hit", 32'(pred_taken_o), 32'(BTB_ON));
    idle_inputs(); rst = 1'b0; tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ce", 32'(ce), 32'h0);
    idle_inputs(); tick();
    chk("rel_pc", pc, 32'h0);
    idle_inputs(); br(32'h10); tick();
    chk("post_rst_hit", 32'(pred_taken_o), 32'h0);
    idle_inputs(); tick();
    chk("post_rst_follow", pc, 32'h14);

    // Randomized traffic confined to a small address window so BTB slots
    // collide often, with occasional high targets to exercise the wrap.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rst = ($urandom_range(0, 99) >= 2);
      stall = 6'($urandom);
      stall[0] = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      new_pc_i = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 255));
      branch_flag_i = ($urandom_range(0, 6) == 0);
      branch_target_address_i = 32'($urandom_range(0, 255));
      upd_valid_i = ($urandom_range(0, 2) == 0);
      upd_pc_i = 32'($urandom_range(0, 63)) * 4;
      upd_target_i = 32'($urandom_range(0, 255));
      upd_taken_i = ($urandom_range(0, 4) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
